// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between mipsCore and a single-word
// req/ack memory. Define DCACHE_STATS_EN to add the hitCnt/missCnt counter outputs.
module dcache_responder #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dCacheAddr,
  input  logic              dCacheReadEn,
  input  logic              dCacheWriteEn,
  input  logic [31:0]       dCacheWriteData,
  output logic [31:0]       dCacheReadData,
  output logic              dCacheStall,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  input  logic              memAck,
  input  logic [31:0]       memRData
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hitCnt,
  output logic [31:0]       missCnt
`endif
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = ADDR_W - IDXW - 2;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t              state_q, state_d;
  logic                memreq_q, memreq_d;
  logic                memwe_q, memwe_d;
  logic [ADDR_W-1:0]   memaddr_q, memaddr_d;
  logic [31:0]         memwdata_q, memwdata_d;
  logic [LINES-1:0]    valid_q;

  logic [TAGW-1:0]     tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [ADDR_W-1:0]   core_waddr;
  logic [IDXW-1:0]     core_idx, mem_idx;
  logic [TAGW-1:0]     core_tag, mem_tag;
  logic                core_hit, mem_hit;
  logic                stall_c;
  logic [31:0]         rdata_c;
  logic                fill_en, wupd_en;

  // Byte-lane bits are masked rather than sliced off so the whole address bus is consumed.
  assign core_waddr = dCacheAddr & ~(ADDR_W'(3));
  assign core_idx   = dCacheAddr[IDXW+1:2];
  assign core_tag   = dCacheAddr[ADDR_W-1:IDXW+2];
  assign mem_idx    = memaddr_q[IDXW+1:2];
  assign mem_tag    = memaddr_q[ADDR_W-1:IDXW+2];
  assign core_hit   = valid_q[core_idx] && (tag_mem[core_idx] == core_tag);
  assign mem_hit    = valid_q[mem_idx] && (tag_mem[mem_idx] == mem_tag);

  always_comb begin
    state_d    = state_q;
    memreq_d   = memreq_q;
    memwe_d    = memwe_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    stall_c    = 1'b0;
    rdata_c    = 32'h0;
    fill_en    = 1'b0;
    wupd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dCacheWriteEn) begin
          stall_c    = 1'b1;
          state_d    = WRITE;
          memreq_d   = 1'b1;
          memwe_d    = 1'b1;
          memaddr_d  = core_waddr;
          memwdata_d = dCacheWriteData;
        end else if (dCacheReadEn) begin
          if (core_hit) begin
            rdata_c = data_mem[core_idx];
          end else begin
            stall_c   = 1'b1;
            state_d   = REFILL;
            memreq_d  = 1'b1;
            memwe_d   = 1'b0;
            memaddr_d = core_waddr;
          end
        end
      end
      REFILL: begin
        stall_c = 1'b1;
        if (memAck) begin
          fill_en  = 1'b1;
          memreq_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        stall_c = 1'b1;
        if (memAck) begin
          // Write-through only refreshes a line that already holds this address.
          wupd_en  = mem_hit;
          memreq_d = 1'b0;
          memwe_d  = 1'b0;
          state_d  = WDONE;
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dCacheStall    = rst & stall_c;
  assign dCacheReadData = rst ? rdata_c : 32'h0;
  assign memReq         = memreq_q;
  assign memWe          = memwe_q;
  assign memAddr        = memaddr_q;
  assign memWData       = memwdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      memreq_q   <= 1'b0;
      memwe_q    <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= 32'h0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      memreq_q   <= memreq_d;
      memwe_q    <= memwe_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      if (fill_en) valid_q[mem_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rst && fill_en) begin
      tag_mem[mem_idx]  <= mem_tag;
      data_mem[mem_idx] <= memRData;
    end else if (rst && wupd_en) begin
      data_mem[mem_idx] <= memwdata_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hitcnt_q, misscnt_q;

  assign hit_evt  = (state_q == IDLE) && !dCacheWriteEn && dCacheReadEn && core_hit;
  assign miss_evt = (state_q == IDLE) && (state_d == REFILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitcnt_q  <= 32'h0;
      misscnt_q <= 32'h0;
    end else begin
      if (hit_evt)  hitcnt_q  <= hitcnt_q + 32'd1;
      if (miss_evt) misscnt_q <= misscnt_q + 32'd1;
    end
  end

  assign hitCnt  = hitcnt_q;
  assign missCnt = misscnt_q;
`endif

endmodule
